vram_arbiter: RTL

- Shares the single-port video memory between the VGA scan-out reader and two pixel-writer requesters.
  - Writer 0: the keyboard/terminal path.
  - Writer 1: the CPU/debug path.
- The display read has absolute priority. Accepted writes are buffered in a small FIFO and drained only into cycles when the display does not need the memory.
- Sits between vga_ctrl/pixel address generation and the memory array.

---
 rtl/vram_arbiter_if.sv | 38 +++
 rtl/vram_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display, writer and memory-port signals of vram_arbiter.
interface vram_arbiter_if #(
    parameter int AW = 19,
    parameter int DW = 24,
    parameter int DEPTH = 4
);
    logic                        disp_req;
    logic [AW-1:0]               disp_addr;
    logic [DW-1:0]               disp_data;
    logic                        disp_vld;
    logic                        w0_valid;
    logic [AW-1:0]               w0_addr;
    logic [DW-1:0]               w0_data;
    logic                        w0_ready;
    logic                        w1_valid;
    logic [AW-1:0]               w1_addr;
    logic [DW-1:0]               w1_data;
    logic                        w1_ready;
    logic                        mem_en;
    logic                        mem_we;
    logic [AW-1:0]               mem_addr;
    logic [DW-1:0]               mem_wdata;
    logic [DW-1:0]               mem_rdata;
    logic [$clog2(DEPTH):0]      fifo_cnt;

    modport slave (
        input  disp_req, disp_addr, w0_valid, w0_addr, w0_data,
               w1_valid, w1_addr, w1_data, mem_rdata,
        output disp_data, disp_vld, w0_ready, w1_ready,
               mem_en, mem_we, mem_addr, mem_wdata, fifo_cnt
    );
    modport master (
        output disp_req, disp_addr, w0_valid, w0_addr, w0_data,
               w1_valid, w1_addr, w1_data, mem_rdata,
        input  disp_data, disp_vld, w0_ready, w1_ready,
               mem_en, mem_we, mem_addr, mem_wdata, fifo_cnt
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: display-priority VRAM port sharing with a round-robin write FIFO.
// Define VRAM_ARB_STATS_EN to add the wr_commits_o / stall_max_o counters.
module vram_arbiter #(
    parameter int AW = 19,
    parameter int DW = 24,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    vram_arbiter_if.slave bus
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0] wr_commits_o,
    output logic [15:0] stall_max_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rr_q, rr_d, vld_q;
    logic [DW-1:0] hold_q;
    logic          space, nonempty, push0, push1, push, pop;

    // Capacity uses the registered count only: a full FIFO never accepts, even while popping.
    always_comb begin
        space = cnt_q < CW'(DEPTH);
        nonempty = cnt_q != '0;
        bus.w0_ready = !rst && space && (!bus.w1_valid || !rr_q);
        bus.w1_ready = !rst && space && (!bus.w0_valid || rr_q);
        push0 = bus.w0_valid && bus.w0_ready;
        push1 = bus.w1_valid && bus.w1_ready;
        push = push0 || push1;
        pop = !rst && !bus.disp_req && nonempty;
        bus.mem_en = !rst && (bus.disp_req || nonempty);
        bus.mem_we = pop;
        bus.mem_addr = bus.disp_req ? bus.disp_addr : addr_q[rd_q];
        bus.mem_wdata = data_q[rd_q];
        bus.disp_vld = vld_q;
        bus.disp_data = vld_q ? bus.mem_rdata : hold_q;
        bus.fifo_cnt = cnt_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        rr_d = push0 ? 1'b1 : push1 ? 1'b0 : rr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
            rr_q <= 1'b0;
            vld_q <= 1'b0;
            hold_q <= '0;
        end else begin
            rd_q <= rd_q + PW'(pop);
            wr_q <= wr_q + PW'(push);
            cnt_q <= cnt_d;
            rr_q <= rr_d;
            vld_q <= bus.disp_req;
            hold_q <= bus.disp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_q] <= push0 ? bus.w0_addr : bus.w1_addr;
            data_q[wr_q] <= push0 ? bus.w0_data : bus.w1_data;
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] commits_q, run_q, run_d, max_q;

    always_comb run_d = (bus.disp_req && nonempty) ? run_q + 16'(run_q != 16'hFFFF) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            commits_q <= '0;
            run_q <= '0;
            max_q <= '0;
        end else begin
            commits_q <= commits_q + 16'(pop);
            run_q <= run_d;
            max_q <= (run_d > max_q) ? run_d : max_q;
        end
    end

    assign wr_commits_o = commits_q;
    assign stall_max_o = max_q;
`endif
endmodule
